// File: rtl/delay_timer_sched.sv
// delay_timer_sched: round-robin scheduler sharing one delay_timer among four requesters.
// Define DTS_TIMEOUT_EN to build the WAIT timeout counter that drives err; otherwise err is 0.
module delay_timer_sched #(
    parameter int HOLD    = 8,
    parameter int QUIET   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [7:0]  req_mode,
    input  logic [31:0] req_weight,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        fired,
    output logic        err,
    output logic        busy,
    output logic        tmr_trigger,
    output logic [1:0]  tmr_mode,
    output logic [7:0]  tmr_weight,
    input  logic        tmr_out
);
    typedef enum logic [2:0] {IDLE, SETUP, TRIG, WAIT, DONE} state_t;

    localparam logic [7:0] HOLD_M1  = 8'(HOLD - 1);
    localparam logic [7:0] QUIET_M1 = 8'(QUIET - 1);

    if (HOLD < 1 || HOLD > 255 || QUIET < 1 || QUIET > 255 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
        $error("delay_timer_sched: parameter out of range");
    end

    state_t     state;
    logic [1:0] last;
    logic [1:0] owner;
    logic [1:0] pick;
    logic       found;
    logic       abort;
    logic [7:0] hold_cnt;
    logic [7:0] quiet_cnt;
`ifdef DTS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // first pending request searching upward from last+1, wrapping mod 4
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[last + 2'(i)]) begin
                pick  = last + 2'(i);
                found = 1'b1;
            end
        end
    end

    // owner withdrew its request while the job is still in flight
    assign abort = (state == SETUP || state == TRIG || state == WAIT) && !req[owner];

    // job sequencer: grant, setup, trigger pulse, quiet wait, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 2'd3;
            owner       <= 2'd0;
            grant       <= 4'd0;
            done        <= 4'd0;
            fired       <= 1'b0;
            busy        <= 1'b0;
            tmr_trigger <= 1'b0;
            tmr_mode    <= 2'd0;
            tmr_weight  <= 8'd0;
            hold_cnt    <= 8'd0;
            quiet_cnt   <= 8'd0;
`ifdef DTS_TIMEOUT_EN
            err         <= 1'b0;
            wait_cnt    <= 16'd0;
`endif
        end else begin
            done <= 4'd0;
            if (abort) begin
                state       <= IDLE;
                grant       <= 4'd0;
                busy        <= 1'b0;
                tmr_trigger <= 1'b0;
                last        <= owner;
            end else begin
                case (state)
                    IDLE: if (found) begin
                        state      <= SETUP;
                        owner      <= pick;
                        grant      <= 4'b0001 << pick;
                        busy       <= 1'b1;
                        tmr_mode   <= req_mode[{pick, 1'b0} +: 2];
                        tmr_weight <= req_weight[{pick, 3'b000} +: 8];
                        fired      <= 1'b0;
`ifdef DTS_TIMEOUT_EN
                        err        <= 1'b0;
`endif
                    end
                    SETUP: begin
                        fired       <= fired | tmr_out;
                        tmr_trigger <= 1'b1;
                        hold_cnt    <= 8'd0;
                        state       <= TRIG;
                    end
                    TRIG: begin
                        fired <= fired | tmr_out;
                        if (hold_cnt == HOLD_M1) begin
                            tmr_trigger <= 1'b0;
                            quiet_cnt   <= 8'd0;
`ifdef DTS_TIMEOUT_EN
                            wait_cnt    <= 16'd0;
`endif
                            state       <= WAIT;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    WAIT: begin
                        fired <= fired | tmr_out;
`ifdef DTS_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                        if (!tmr_out && quiet_cnt == QUIET_M1) begin
                            state <= DONE;
                            done  <= grant;
                        end
`ifdef DTS_TIMEOUT_EN
                        else if (wait_cnt == TIMEOUT_M1) begin
                            state <= DONE;
                            done  <= grant;
                            err   <= 1'b1;
                        end
`endif
                        else begin
                            quiet_cnt <= tmr_out ? 8'd0 : quiet_cnt + 8'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        grant <= 4'd0;
                        busy  <= 1'b0;
                        last  <= owner;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_delay_timer_sched.sv
// tb_delay_timer_sched: directed checks of grant order, job timing, fired/err flags, abort and reset.
module tb_delay_timer_sched;
    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_mode;
    logic [31:0] req_weight;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        fired;
    logic        err;
    logic        busy;
    logic        tmr_trigger;
    logic [1:0]  tmr_mode;
    logic [7:0]  tmr_weight;
    logic        tmr_out;

    int errors = 0;
    int checks = 0;

    int         r_gn, r_tf, r_tc, r_dn, r_bad;
    logic [3:0] r_gv, r_dv;
    logic       r_fv, r_ev;

    delay_timer_sched #(.HOLD(8), .QUIET(16), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .req_mode(req_mode), .req_weight(req_weight),
        .grant(grant), .done(done), .fired(fired), .err(err), .busy(busy),
        .tmr_trigger(tmr_trigger), .tmr_mode(tmr_mode), .tmr_weight(tmr_weight), .tmr_out(tmr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs up to maxn cycles sampling on negedges; n=1 is the cycle after the call.
    // tmr_out is driven high for cycles lo..hi; requester fields are scrambled mid-job.
    task automatic run(input int maxn, input int lo, input int hi, input logic drop,
                       input logic [1:0] em, input logic [7:0] ew);
        logic [7:0]  sm;
        logic [31:0] sw;
        sm = req_mode;
        sw = req_weight;
        r_gn = 0; r_gv = 0; r_tf = 0; r_tc = 0; r_dn = 0; r_dv = 0; r_fv = 0; r_ev = 0; r_bad = 0;
        for (int n = 1; n <= maxn; n++) begin
            @(negedge clk);
            if (r_gn == 0 && grant != 4'd0) begin
                r_gn = n;
                r_gv = grant;
            end
            if (tmr_trigger) begin
                r_tc++;
                if (r_tf == 0) r_tf = n;
            end
            if (busy && grant != 4'd0 && (tmr_mode !== em || tmr_weight !== ew)) r_bad++;
            if (n == 3) begin
                req_mode = ~sm;
                req_weight = ~sw;
            end
            tmr_out = (n >= lo && n <= hi);
            if (done != 4'd0) begin
                r_dn = n;
                r_dv = done;
                r_fv = fired;
                r_ev = err;
                if (drop) req = req & ~done;
                break;
            end
        end
        req_mode = sm;
        req_weight = sw;
        tmr_out = 1'b0;
    endtask

    logic [1:0] o;
    logic [3:0] dacc;

    initial begin
        reset = 1'b1;
        req = 4'd0;
        req_mode = 8'b11_10_01_00;
        req_weight = 32'h40302010;
        tmr_out = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", {grant, done, busy, tmr_trigger, tmr_mode, tmr_weight, fired, err}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", {grant, done, busy, tmr_trigger, tmr_mode, tmr_weight, fired, err}, 0);

        // round robin, all four requesting, starting from requester 0
        req = 4'b1111;
        run(100, 0, 0, 1'b0, 2'd0, 8'h10);
        check("rr0_grant", r_gv, 4'b0001);
        check("rr0_grant_cyc", r_gn, 1);
        check("rr0_trig_first", r_tf, 2);
        check("rr0_trig_len", r_tc, 8);
        check("rr0_done_cyc", r_dn, 26);
        check("rr0_done", r_dv, 4'b0001);
        check("rr0_stable", r_bad, 0);
        for (int i = 1; i <= 4; i++) begin
            o = 2'(i % 4);
            run(100, 0, 0, 1'b0, o, 8'(16 * (int'(o) + 1)));
            check("rr_grant", r_gv, 4'b0001 << o);
            check("rr_grant_cyc", r_gn, 2);
            check("rr_done_cyc", r_dn, 27);
            check("rr_done", r_dv, 4'b0001 << o);
            check("rr_stable", r_bad, 0);
        end
        req = 4'd0;
        @(negedge clk);
        @(negedge clk);

        // abort: requester 1 drops during TRIG, pending requester 2 goes next
        req = 4'b0110;
        dacc = 4'd0;
        @(negedge clk);
        check("ab_grant", grant, 4'b0010);
        dacc |= done;
        @(negedge clk);
        dacc |= done;
        @(negedge clk);
        dacc |= done;
        @(negedge clk);
        dacc |= done;
        check("ab_trig_before", tmr_trigger, 1'b1);
        req = 4'b0100;
        @(negedge clk);
        dacc |= done;
        check("ab_trig_after", {tmr_trigger, busy, grant}, 6'd0);
        check("ab_no_done", dacc, 4'd0);
        @(negedge clk);
        check("ab_next_grant", grant, 4'b0100);
        run(100, 0, 0, 1'b1, 2'b10, 8'h30);
        check("ab_job2_done", r_dv, 4'b0100);
        check("ab_job2_cyc", r_dn, 25);
        @(negedge clk);

        // single job on requester 2 with tmr_out quiet
        req_mode[5:4] = 2'b11;
        req_weight[23:16] = 8'h03;
        req = 4'b0100;
        run(100, 0, 0, 1'b1, 2'b11, 8'h03);
        check("sj_trig_first", r_tf, 2);
        check("sj_trig_len", r_tc, 8);
        check("sj_done_cyc", r_dn, 26);
        check("sj_done", r_dv, 4'b0100);
        check("sj_fired", r_fv, 1'b0);
        check("sj_err", r_ev, 1'b0);
        check("sj_stable", r_bad, 0);
        check("sj_req_dropped", req, 4'd0);
        @(negedge clk);

        // fired: tmr_out high in cycles 9..12 delays completion to cycle 29
        req_mode[3:2] = 2'b11;
        req_weight[15:8] = 8'h03;
        req = 4'b0010;
        run(100, 9, 12, 1'b1, 2'b11, 8'h03);
        check("fi_done", r_dv, 4'b0010);
        check("fi_done_cyc", r_dn, 29);
        check("fi_fired", r_fv, 1'b1);
        check("fi_err", r_ev, 1'b0);
        check("fi_stable", r_bad, 0);
        @(negedge clk);

        // tmr_out stuck high on requester 3
        req = 4'b1000;
        run(1000, 1, 2000, 1'b0, 2'b11, 8'h40);
`ifdef DTS_TIMEOUT_EN
        check("to_done", r_dv, 4'b1000);
        check("to_done_cyc", r_dn, 74);
        check("to_err", r_ev, 1'b1);
        check("to_fired", r_fv, 1'b1);
        req = 4'd0;
        @(negedge clk);
`else
        check("to_no_done", r_dv, 4'd0);
        check("to_still_busy", {busy, grant}, 5'b1_1000);
        req = 4'd0;
        @(negedge clk);
        check("to_abort_idle", {busy, grant}, 5'd0);
`endif
        @(negedge clk);

        // asynchronous reset in the middle of TRIG
        req = 4'b0010;
        repeat (4) @(negedge clk);
        check("rs_in_trig", {tmr_trigger, grant}, 5'b1_0010);
        #2 reset = 1'b1;
        #1;
        check("rs_async_outs", {grant, done, busy, tmr_trigger, tmr_mode, tmr_weight, fired, err}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check("rs_first_grant", grant, 4'b0001);
        req = 4'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
